// File: rtl/dram_ctrl_param.sv
// Word-addressed data memory with configurable latency, a busy/data_valid
// handshake and periodic refresh stalls that block new requests.
module dram_ctrl_param #(
  parameter int DATA_W         = 24,
  parameter int ADDR_W         = 24,
  parameter int DEPTH_LOG2     = 8,
  parameter int LATENCY        = 2,
  parameter int REFRESH_PERIOD = 64,
  parameter int REFRESH_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              write,
  input  logic              read,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              busy
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int LAT_W = $clog2(LATENCY + 1);
  localparam int RC_W  = $clog2(REFRESH_CYCLES + 1);
  localparam int RP_W  = $clog2(REFRESH_PERIOD > 1 ? REFRESH_PERIOD : 2);

  typedef enum logic [1:0] {IDLE, ACCESS, REFRESH} state_t;

  state_t                  state;
  logic [DATA_W-1:0]       mem [DEPTH];
  logic [LAT_W-1:0]        lat_cnt;
  logic [RC_W-1:0]         ref_cnt;
  logic                    pending;
  logic                    wrap;
  logic                    in_range;
  logic                    accept;
  logic [DEPTH_LOG2-1:0]   req_addr_p0;
  logic                    req_read_p0;
  logic                    req_oor_p0;

  assign in_range = ((addr_in >> DEPTH_LOG2) == '0);
  assign accept   = reset && (state == IDLE) && !pending && (read || write);

  // Free-running refresh timer; wrap marks a refresh as due.
  generate
    if (REFRESH_PERIOD > 0) begin : g_refresh
      logic [RP_W-1:0] ref_timer;

      assign wrap = (ref_timer == RP_W'(REFRESH_PERIOD - 1));

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          ref_timer <= '0;
        end else if (wrap) begin
          ref_timer <= '0;
        end else begin
          ref_timer <= ref_timer + 1'b1;
        end
      end
    end else begin : g_no_refresh
      assign wrap = 1'b0;
    end
  endgenerate

  // Storage is not reset; writes commit at the acceptance edge.
  always_ff @(posedge clk) begin
    if (accept && write && in_range) begin
      mem[addr_in[DEPTH_LOG2-1:0]] <= data_in;
    end
  end

  // Request stage (_p0) latched at acceptance, completed LATENCY edges later.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      busy        <= 1'b0;
      data_valid  <= 1'b0;
      data_out    <= '0;
      lat_cnt     <= '0;
      ref_cnt     <= '0;
      pending     <= 1'b0;
      req_addr_p0 <= '0;
      req_read_p0 <= 1'b0;
      req_oor_p0  <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      if (wrap) begin
        pending <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (pending) begin
            state   <= REFRESH;
            busy    <= 1'b1;
            ref_cnt <= RC_W'(REFRESH_CYCLES - 1);
            pending <= wrap;
          end else if (read || write) begin
            state       <= ACCESS;
            busy        <= 1'b1;
            lat_cnt     <= LAT_W'(LATENCY - 1);
            req_addr_p0 <= addr_in[DEPTH_LOG2-1:0];
            req_read_p0 <= !write;
            req_oor_p0  <= !in_range;
          end
        end
        ACCESS: begin
          if (lat_cnt == '0) begin
            state <= IDLE;
            busy  <= 1'b0;
            if (req_read_p0) begin
              data_out   <= req_oor_p0 ? '0 : mem[req_addr_p0];
              data_valid <= 1'b1;
            end
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end
        REFRESH: begin
          if (ref_cnt == '0) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            ref_cnt <= ref_cnt - 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dram_ctrl_param.sv
// Directed bench: table of single transactions on a refresh-free instance,
// plus reset-abort and refresh-stall sequences on a second instance.
module tb_dram_ctrl_param;

  logic        clk = 1'b0;
  logic        rst_a, write_a, read_a;
  logic [23:0] addr_a, data_a, dout_a;
  logic        dv_a, busy_a;
  logic        rst_b, write_b, read_b;
  logic [23:0] addr_b, data_b, dout_b;
  logic        dv_b, busy_b;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dram_ctrl_param #(.REFRESH_PERIOD(0)) u_a (
    .clk(clk), .reset(rst_a), .write(write_a), .read(read_a),
    .addr_in(addr_a), .data_in(data_a), .data_out(dout_a),
    .data_valid(dv_a), .busy(busy_a)
  );

  dram_ctrl_param #(.REFRESH_PERIOD(8), .REFRESH_CYCLES(4)) u_b (
    .clk(clk), .reset(rst_b), .write(write_b), .read(read_b),
    .addr_in(addr_b), .data_in(data_b), .data_out(dout_b),
    .data_valid(dv_b), .busy(busy_b)
  );

  typedef struct {
    logic        wr;
    logic        rd;
    logic [23:0] addr;
    logic [23:0] data;
    logic        exp_dv;
    logic [23:0] exp_dout;
    bit          gap;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one request at a negedge, then follow it to completion.
  task automatic run_op(input vec_t v, input int idx);
    write_a = v.wr;
    read_a  = v.rd;
    addr_a  = v.addr;
    data_a  = v.data;
    @(posedge clk); @(negedge clk);
    write_a = 1'b0;
    read_a  = 1'b0;
    check($sformatf("v%0d busy k", idx), busy_a, 1);
    check($sformatf("v%0d dv k", idx), dv_a, 0);
    @(posedge clk); @(negedge clk);
    check($sformatf("v%0d busy k+1", idx), busy_a, 1);
    check($sformatf("v%0d dv k+1", idx), dv_a, 0);
    @(posedge clk); @(negedge clk);
    check($sformatf("v%0d busy k+2", idx), busy_a, 0);
    check($sformatf("v%0d dv k+2", idx), dv_a, v.exp_dv);
    check($sformatf("v%0d dout k+2", idx), dout_a, v.exp_dout);
    if (v.gap) begin
      @(posedge clk); @(negedge clk);
      check($sformatf("v%0d busy idle", idx), busy_a, 0);
      check($sformatf("v%0d dv idle", idx), dv_a, 0);
      check($sformatf("v%0d dout hold", idx), dout_a, v.exp_dout);
    end
  endtask

  initial begin
    rst_a = 1'b0; write_a = 1'b0; read_a = 1'b0; addr_a = '0; data_a = '0;
    rst_b = 1'b0; write_b = 1'b0; read_b = 1'b1; addr_b = '0; data_b = '0;

    //           wr    rd    addr        data        dv    dout        gap
    vecs[0]  = '{1'b1, 1'b0, 24'd1,      24'd100,    1'b0, 24'd0,      1'b1};
    vecs[1]  = '{1'b0, 1'b1, 24'd1,      24'd0,      1'b1, 24'd100,    1'b1};
    vecs[2]  = '{1'b1, 1'b0, 24'd2,      24'd5,      1'b0, 24'd100,    1'b0};
    vecs[3]  = '{1'b0, 1'b1, 24'd2,      24'd0,      1'b1, 24'd5,      1'b0};
    vecs[4]  = '{1'b0, 1'b1, 24'd1,      24'd0,      1'b1, 24'd100,    1'b1};
    vecs[5]  = '{1'b1, 1'b1, 24'd3,      24'd7,      1'b0, 24'd100,    1'b1};
    vecs[6]  = '{1'b0, 1'b1, 24'd3,      24'd0,      1'b1, 24'd7,      1'b1};
    vecs[7]  = '{1'b1, 1'b0, 24'd0,      24'd42,     1'b0, 24'd7,      1'b1};
    vecs[8]  = '{1'b1, 1'b0, 24'h000100, 24'd9,      1'b0, 24'd7,      1'b1};
    vecs[9]  = '{1'b0, 1'b1, 24'd0,      24'd0,      1'b1, 24'd42,     1'b1};
    vecs[10] = '{1'b0, 1'b1, 24'h000100, 24'd0,      1'b1, 24'd0,      1'b1};
    vecs[11] = '{1'b0, 1'b1, 24'h800001, 24'd0,      1'b1, 24'd0,      1'b1};
    vecs[12] = '{1'b1, 1'b0, 24'h0000FF, 24'hFFFFFF, 1'b0, 24'd0,      1'b0};
    vecs[13] = '{1'b0, 1'b1, 24'h0000FF, 24'd0,      1'b1, 24'hFFFFFF, 1'b1};

    repeat (2) @(negedge clk);
    check("reset busy", busy_a, 0);
    check("reset dv", dv_a, 0);
    check("reset dout", dout_a, 0);
    rst_a = 1'b1;
    @(posedge clk); @(negedge clk);
    check("post-reset busy", busy_a, 0);

    for (int i = 0; i < 14; i++) begin
      run_op(vecs[i], i);
    end

    // Reset during cycle 1 of a read aborts it with no pulse.
    read_a = 1'b1; addr_a = 24'd2;
    @(posedge clk); @(negedge clk);
    read_a = 1'b0;
    check("abort rd busy before", busy_a, 1);
    #2 rst_a = 1'b0;
    #1;
    check("abort rd busy", busy_a, 0);
    check("abort rd dout", dout_a, 0);
    check("abort rd dv", dv_a, 0);
    @(negedge clk);
    rst_a = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); @(negedge clk);
      check($sformatf("abort rd quiet %0d", i), dv_a, 0);
      check($sformatf("abort rd idle %0d", i), busy_a, 0);
    end
    run_op('{1'b0, 1'b1, 24'd1, 24'd0, 1'b1, 24'd100, 1'b1}, 20);
    run_op('{1'b0, 1'b1, 24'd2, 24'd0, 1'b1, 24'd5, 1'b1}, 21);

    // Reset during a write still leaves the write committed.
    write_a = 1'b1; addr_a = 24'd4; data_a = 24'd77;
    @(posedge clk); @(negedge clk);
    write_a = 1'b0;
    #2 rst_a = 1'b0;
    #1;
    check("abort wr busy", busy_a, 0);
    @(negedge clk);
    rst_a = 1'b1;
    @(negedge clk);
    run_op('{1'b0, 1'b1, 24'd4, 24'd0, 1'b1, 24'd77, 1'b1}, 22);

    // Refresh instance: read held from reset release; edge n counted from release.
    @(negedge clk);
    rst_b = 1'b1;
    for (int n = 1; n <= 30; n++) begin
      @(posedge clk); @(negedge clk);
      check($sformatf("refresh busy edge %0d", n), busy_b,
            (n inside {3, 6, 9, 14, 17, 22, 25, 30}) ? 0 : 1);
      check($sformatf("refresh dv edge %0d", n), dv_b,
            (n inside {3, 6, 9, 17, 25}) ? 1 : 0);
    end
    read_b = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dram_ctrl_param.md
Name: dram_ctrl_param

Overview:
- Parametrised successor to the single-cycle DRAM model: a word-addressed data memory with configurable width, depth and access latency.
- Adds a busy/data_valid handshake and periodic refresh stalls.
- Sits between the processor's load/store path and main data storage; the processor must hold requests until busy is low.

Parameters:
- DATA_W, 24, data word width in bits.
- ADDR_W, 24, width of addr_in.
- DEPTH_LOG2, 8, log2 of the number of words; only addr_in[DEPTH_LOG2-1:0] index storage.
- LATENCY, 2, cycles from request acceptance to completion; must be at least 1.
- REFRESH_PERIOD, 64, cycles between refresh requests; 0 disables refresh.
- REFRESH_CYCLES, 4, cycles the memory stays busy per refresh; must be at least 1.

Ports:
- clk, input, 1, rising-edge clock.
- reset, input, 1, asynchronous active-low reset.
- write, input, 1, write request.
- read, input, 1, read request.
- addr_in, input, ADDR_W, word address.
- data_in, input, DATA_W, write data.
- data_out, output, DATA_W, read data; holds its value until the next read completes.
- data_valid, output, 1, one-cycle pulse when data_out carries new read data.
- busy, output, 1, high while an access or refresh is in progress; requests are ignored while it is high.

Behaviour:
- Reset (reset=0, asynchronous):
  - data_out=0, data_valid=0, busy=0, state=IDLE.
  - Latency counter, refresh counter and refresh-pending flag cleared.
  - Memory contents are not cleared.
- FSM states:
  - IDLE: busy=0.
  - ACCESS: busy=1, latency counter running.
  - REFRESH: busy=1, refresh counter running.
- Request acceptance:
  - A request is accepted at rising edge k if state=IDLE, no refresh is pending, and read or write is 1.
  - On acceptance, addr_in, data_in and the operation type are latched; state goes to ACCESS; busy=1 from edge k.
- write and read both high: write wins and the read is dropped; no data_valid pulse.
- Write: memory is updated at acceptance edge k; busy stays high for LATENCY cycles.
- Read:
  - At edge k+LATENCY, data_out is loaded with mem[latched addr], data_valid=1 for one cycle, busy=0, state returns to IDLE.
  - A new request is accepted at edge k+LATENCY+1 at the earliest.
- Write completion: at edge k+LATENCY, busy=0 and state returns to IDLE; data_valid stays 0.
- Read-after-write to the same address returns the new data.
- Out of range: if any addr_in bit at or above DEPTH_LOG2 is 1:
  - A write is accepted but does not modify memory.
  - A read completes with data_out=0 and data_valid=1.
  - Timing is identical to an in-range access.
- Refresh (only when REFRESH_PERIOD is nonzero):
  - A free-running counter counts 0..REFRESH_PERIOD-1; the pending flag is set on wrap.
  - In IDLE with pending set, the block enters REFRESH at the next edge and clears pending; busy=1 for REFRESH_CYCLES cycles, then returns to IDLE.
  - Refresh takes priority over a request arriving at the same edge; that request is ignored and must be held.
  - A refresh that falls due during ACCESS stays pending and starts at the edge after ACCESS completes.
  - A second wrap while pending is still set is absorbed; refreshes never queue more than one deep.
- Reset mid-operation:
  - An in-flight access is aborted immediately; no data_valid pulse.
  - A write already accepted remains committed to memory.
- busy and data_valid are registered outputs with no combinational path from inputs.

Test Plan:
- Reset, then write 24'd100 to addr 1 (held one cycle while busy=0) -> busy high for 2 cycles. Then read addr 1 -> data_valid pulses exactly 2 edges after acceptance with data_out=100.
- Write 24'd5 to addr 2, then read addr 2 immediately after busy drops -> data_out=5. Read addr 1 next -> data_out=100, and data_out holds 100 between reads.
- write=1 and read=1 together, addr 3, data 24'd7 -> no data_valid pulse. A later read of addr 3 -> 7.
- Out of range: write 24'd9 to addr 24'h000100 -> mem[0] unchanged. Read addr 24'h000100 -> data_out=0 with data_valid=1.
- Refresh, REFRESH_PERIOD=8, REFRESH_CYCLES=4, read held continuously -> a 4-cycle busy window occurs every 8 cycles. No request is accepted during it, and held reads are served after it ends.
- Assert reset during cycle 1 of a read ACCESS -> busy=0 and data_out=0 immediately, with no data_valid pulse. A previously written address still reads back its data after reset.
